// File: rtl/div_rate_sched_pkg.sv
// Shared types and constants for the divider rate scheduler.
package div_rate_sched_pkg;

  localparam int DELAY_W = 32;
  localparam logic [DELAY_W-1:0] MIN_DELAY = 32'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    RUN    = 2'd2
  } state_t;

  // The divider cannot run with a delay below MIN_DELAY.
  function automatic logic [DELAY_W-1:0] clamp_delay(input logic [DELAY_W-1:0] d);
    return (d < MIN_DELAY) ? MIN_DELAY : d;
  endfunction

endpackage

// File: rtl/div_rate_sched_edge_sync_rise.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous input.
module edge_sync_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= d;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign rise = sync2_reg & ~prev_reg;

endmodule

// File: rtl/div_rate_sched.sv
// Fixed-priority sharing of one programmable divider; delay changes land only
// on a divided-clock rising edge or after a stall timeout.
module div_rate_sched
  import div_rate_sched_pkg::*;
#(
  parameter int                 N          = 4,
  parameter logic [DELAY_W-1:0] IDLE_DELAY = 32'd100_000,
  parameter int unsigned        MIN_HOLD   = 2,
  parameter logic [DELAY_W-1:0] TIMEOUT    = 32'd50_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [DELAY_W*N-1:0] delay_cfg,
  input  logic                 div_clk,
  output logic [DELAY_W-1:0]   delay,
  output logic [N-1:0]         gnt,
  output logic                 busy,
  output logic                 switched
);

  localparam int IW = $clog2(N);
  localparam logic [DELAY_W-1:0] TMO_LAST = (TIMEOUT == '0) ? '0 : TIMEOUT - 32'd1;

  state_t             state_reg;
  logic [DELAY_W-1:0] delay_reg;
  logic [N-1:0]       gnt_reg;
  logic [IW-1:0]      gnt_idx_reg;
  logic               busy_reg;
  logic               switched_reg;
  logic [31:0]        tmo_cnt_reg;
  logic [31:0]        hold_cnt_reg;

  logic               rise;
  logic               win_valid;
  logic [IW-1:0]      win_idx;
  logic [DELAY_W-1:0] eff_delay [N];
  logic [DELAY_W-1:0] win_delay;
  logic [N-1:0]       win_onehot;
  logic               gnt_held;
  logic               boundary;
  logic               run_leave;

  edge_sync_rise u_div_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (div_clk),
    .rise  (rise)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_clamp
    assign eff_delay[gi] = clamp_delay(delay_cfg[DELAY_W*gi +: DELAY_W]);
  end

  // Lowest set index wins; scanning downward leaves the smallest index last.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_valid = 1'b1;
        win_idx   = IW'(i);
      end
    end
  end

  assign win_delay  = win_valid ? eff_delay[win_idx] : IDLE_DELAY;
  assign win_onehot = win_valid ? (N'(1) << win_idx) : '0;
  assign gnt_held   = req[gnt_idx_reg];
  assign boundary   = rise || (tmo_cnt_reg == TMO_LAST);
  assign run_leave  = !gnt_held
                   || ((win_idx < gnt_idx_reg) && (hold_cnt_reg == MIN_HOLD))
                   || (eff_delay[gnt_idx_reg] != delay_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      delay_reg    <= IDLE_DELAY;
      gnt_reg      <= '0;
      gnt_idx_reg  <= '0;
      busy_reg     <= 1'b0;
      switched_reg <= 1'b0;
      tmo_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
    end else begin
      switched_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            state_reg   <= SWITCH;
            busy_reg    <= 1'b1;
            tmo_cnt_reg <= '0;
          end
        end
        SWITCH: begin
          // The target is the live winner, so retargeting costs no timeout restart.
          if (boundary) begin
            delay_reg    <= win_delay;
            gnt_reg      <= win_onehot;
            gnt_idx_reg  <= win_idx;
            switched_reg <= 1'b1;
            busy_reg     <= 1'b0;
            tmo_cnt_reg  <= '0;
            hold_cnt_reg <= '0;
            state_reg    <= win_valid ? RUN : IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
          end
        end
        RUN: begin
          if (rise && (hold_cnt_reg != MIN_HOLD))
            hold_cnt_reg <= hold_cnt_reg + 32'd1;
          if (run_leave) begin
            state_reg   <= SWITCH;
            busy_reg    <= 1'b1;
            tmo_cnt_reg <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign delay    = delay_reg;
  assign gnt      = gnt_reg;
  assign busy     = busy_reg;
  assign switched = switched_reg;

endmodule

// File: tb/tb_div_rate_sched.sv
// Directed bench for div_rate_sched: arbitration, hold, clamp, timeout, retarget, async reset.
module tb_div_rate_sched;

  localparam logic [31:0] IDLE_D = 32'd100_000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] delay_cfg;
  logic         div_clk;
  logic [31:0]  delay;
  logic [3:0]   gnt;
  logic         busy;
  logic         switched;

  int tests  = 0;
  int failed = 0;
  int sw_count = 0;
  int sw_before;
  int found;

  div_rate_sched #(
    .N          (4),
    .IDLE_DELAY (IDLE_D),
    .MIN_HOLD   (2),
    .TIMEOUT    (32'd20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .delay_cfg (delay_cfg),
    .div_clk   (div_clk),
    .delay     (delay),
    .gnt       (gnt),
    .busy      (busy),
    .switched  (switched)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock, then sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (switched === 1'b1) sw_count++;
    if ($countones(gnt) > 1) check("gnt_onehot", 32'(gnt), 32'd0);
  endtask

  // Raise div_clk; its rise is consumed by the FSM on the third clock edge.
  task automatic edge3();
    div_clk = 1'b1;
    repeat (3) tick();
  endtask

  task automatic settle();
    div_clk = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 4'b0000;
    div_clk   = 1'b0;
    delay_cfg = '0;
    delay_cfg[0*32 +: 32] = 32'd6;
    delay_cfg[1*32 +: 32] = 32'd0;
    delay_cfg[2*32 +: 32] = 32'd10;
    delay_cfg[3*32 +: 32] = 32'd77;

    repeat (3) tick();
    check("rst_delay", delay, IDLE_D);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_switched", 32'(switched), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single request for requester 2
    req = 4'b0100;
    tick();
    check("t1_busy_req", 32'(busy), 32'd1);
    check("t1_gnt_pending", 32'(gnt), 32'd0);
    edge3();
    check("t1_switched", 32'(switched), 32'd1);
    check("t1_delay", delay, 32'd10);
    check("t1_gnt", 32'(gnt), 32'b0100);
    check("t1_busy_done", 32'(busy), 32'd0);
    settle();
    check("t1_pulse_len", 32'(sw_count), 32'd1);

    // Preemption by req[0] only after two counted rises
    req = 4'b0101;
    repeat (2) tick();
    check("t2_no_preempt0", 32'(busy), 32'd0);
    edge3();
    settle();
    check("t2_no_preempt1", 32'(busy), 32'd0);
    check("t2_gnt_hold", 32'(gnt), 32'b0100);
    edge3();
    settle();
    check("t2_busy_after2", 32'(busy), 32'd1);
    check("t2_gnt_kept", 32'(gnt), 32'b0100);
    check("t2_sw_count", 32'(sw_count), 32'd1);
    edge3();
    check("t2_switched", 32'(switched), 32'd1);
    check("t2_delay", delay, 32'd6);
    check("t2_gnt", 32'(gnt), 32'b0001);
    settle();

    // Release to req[1] whose cfg 0 clamps to 2
    req = 4'b0010;
    tick();
    check("t3_busy", 32'(busy), 32'd1);
    edge3();
    check("t3_switched", 32'(switched), 32'd1);
    check("t3_delay_clamp", delay, 32'd2);
    check("t3_gnt", 32'(gnt), 32'b0010);
    settle();
    req = 4'b0000;
    tick();
    check("t3_busy_rel", 32'(busy), 32'd1);
    edge3();
    check("t3_delay_idle", delay, IDLE_D);
    check("t3_gnt_none", 32'(gnt), 32'd0);
    settle();

    // Stalled divider: timeout forces the switch
    req = 4'b1000;
    found = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (switched === 1'b1) begin
        found = k;
        break;
      end
    end
    check("t4_timeout_cycle", 32'(found), 32'd21);
    check("t4_delay", delay, 32'd77);
    check("t4_gnt", 32'(gnt), 32'b1000);
    tick();

    // Retarget 2 -> 1 inside SWITCH
    req = 4'b0100;
    tick();
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_gnt_old", 32'(gnt), 32'b1000);
    req = 4'b0110;
    tick();
    sw_before = sw_count;
    edge3();
    check("t5_switched", 32'(switched), 32'd1);
    check("t5_delay", delay, 32'd2);
    check("t5_gnt", 32'(gnt), 32'b0010);
    settle();
    check("t5_single_switch", 32'(sw_count - sw_before), 32'd1);

    // Config change of the granted requester
    delay_cfg[1*32 +: 32] = 32'd1;
    repeat (2) tick();
    check("t6_same_clamp", 32'(busy), 32'd0);
    delay_cfg[1*32 +: 32] = 32'd5;
    tick();
    check("t6_busy_cfg", 32'(busy), 32'd1);
    edge3();
    check("t6_delay_cfg", delay, 32'd5);
    check("t6_gnt_cfg", 32'(gnt), 32'b0010);
    settle();

    // Asynchronous reset in the middle of a switch
    req = 4'b0000;
    tick();
    check("t7_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_async_delay", delay, IDLE_D);
    check("t7_async_gnt", 32'(gnt), 32'd0);
    check("t7_async_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    req = 4'b0001;
    tick();
    check("t7_resume_busy", 32'(busy), 32'd1);
    check("t7_resume_gnt0", 32'(gnt), 32'd0);
    edge3();
    check("t7_resume_sw", 32'(switched), 32'd1);
    check("t7_resume_delay", delay, 32'd6);
    check("t7_resume_gnt", 32'(gnt), 32'b0001);
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
